// File: rtl/core_pkg.sv
// core_pkg: shared FSM state type and default core constants
package core_pkg;
  typedef enum logic [1:0] {BOOT, OFFER, EXEC, HALT} pc_state_e;
  localparam int          DEF_XLEN         = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;
  localparam int          DEF_INCR         = 4;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: priority/alignment selection of the next PC for a resolving instruction
module pc_next_sel import core_pkg::*; #(
  parameter int              XLEN        = DEF_XLEN,
  parameter logic [XLEN-1:0] TRAP_VECTOR = DEF_TRAP_VECTOR,
  parameter int              INCR        = DEF_INCR,
  parameter int              IALIGN_BITS = 2
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] epc,
  input  logic            trap_req,
  input  logic            mret,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            advance,
  output logic            resolved,
  output logic            take_trap,
  output logic            misaligned_d,
  output logic [XLEN-1:0] next_pc
);
  logic bad_target;
  always_comb begin
    bad_target   = redirect_valid && |redirect_target[IALIGN_BITS-1:0];
    resolved     = trap_req || mret || redirect_valid || advance;
    take_trap    = trap_req || (!mret && bad_target);
    misaligned_d = !trap_req && !mret && bad_target;
    next_pc      = take_trap      ? TRAP_VECTOR :
                   mret           ? epc :
                   redirect_valid ? redirect_target :
                   advance        ? pc + XLEN'(INCR) : pc;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: architectural PC holder with fetch handshake, trap entry/return and halt
module pc_sequencer import core_pkg::*; #(
  parameter int              XLEN         = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = DEF_TRAP_VECTOR,
  parameter int              INCR         = DEF_INCR,
  parameter int              IALIGN_BITS  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  input  logic            fetch_ready,
  input  logic            advance,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_req,
  input  logic            mret,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] epc,
  output logic            misaligned,
  output logic            halted
);
  pc_state_e       state;
  logic            halt_pend;
  logic            resolved;
  logic            take_trap;
  logic            misaligned_d;
  logic [XLEN-1:0] next_pc;

  pc_next_sel #(
    .XLEN(XLEN), .TRAP_VECTOR(TRAP_VECTOR), .INCR(INCR), .IALIGN_BITS(IALIGN_BITS)
  ) u_sel (
    .pc(pc), .epc(epc), .trap_req(trap_req), .mret(mret),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .advance(advance),
    .resolved(resolved), .take_trap(take_trap), .misaligned_d(misaligned_d), .next_pc(next_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_VECTOR;
      epc        <= '0;
      pc_valid   <= 1'b0;
      misaligned <= 1'b0;
      halted     <= 1'b0;
      halt_pend  <= 1'b0;
    end else begin
      misaligned <= 1'b0;
      case (state)
        BOOT: begin
          state     <= OFFER;
          pc_valid  <= 1'b1;
          halt_pend <= halt_pend || halt_req;
        end
        OFFER: begin
          halt_pend <= halt_pend || halt_req;
          if (fetch_ready) begin
            state    <= EXEC;
            pc_valid <= 1'b0;
          end
        end
        EXEC: begin
          if (resolved) begin
            pc         <= next_pc;
            misaligned <= misaligned_d;
            if (take_trap) epc <= pc;
            // a pending or same-cycle halt request is consumed by the resolution
            if (halt_req || halt_pend) begin
              state     <= HALT;
              halted    <= 1'b1;
              halt_pend <= 1'b0;
            end else begin
              state    <= OFFER;
              pc_valid <= 1'b1;
            end
          end else begin
            halt_pend <= halt_pend || halt_req;
          end
        end
        HALT: begin
          if (resume) begin
            state    <= OFFER;
            pc_valid <= 1'b1;
            halted   <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks against a transaction-level PC model
module tb_pc_sequencer;
  localparam int P_BOOT = 0, P_OFFER = 1, P_EXEC = 2, P_HALT = 3;
  localparam longint M32 = 64'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n, fetch_ready, advance, redirect_valid, trap_req, mret, halt_req, resume;
  logic [31:0] redirect_target, pc, epc;
  logic        pc_valid, misaligned, halted;

  int     n_tests = 0, n_fail = 0;
  int     m_phase = P_BOOT;
  longint m_pc = 0, m_epc = 0;
  bit     m_hp = 0, m_mis = 0;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_valid(pc_valid), .fetch_ready(fetch_ready),
    .advance(advance), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_req(trap_req), .mret(mret), .halt_req(halt_req), .resume(resume),
    .epc(epc), .misaligned(misaligned), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference: one instruction is offered, accepted, then resolved by its highest-priority event
  task automatic model();
    bit bad;
    m_mis = 0;
    if (!rst_n) begin
      m_phase = P_BOOT; m_pc = 0; m_epc = 0; m_hp = 0;
    end else if (m_phase == P_BOOT) begin
      m_hp = m_hp | halt_req; m_phase = P_OFFER;
    end else if (m_phase == P_OFFER) begin
      m_hp = m_hp | halt_req;
      if (fetch_ready) m_phase = P_EXEC;
    end else if (m_phase == P_HALT) begin
      if (resume) m_phase = P_OFFER;
    end else if (trap_req || mret || redirect_valid || advance) begin
      bad = redirect_valid && (longint'(redirect_target) % 4 != 0);
      if (trap_req || (!mret && bad)) begin
        m_mis = !trap_req; m_epc = m_pc; m_pc = 'h100;
      end else if (mret) m_pc = m_epc;
      else if (redirect_valid) m_pc = longint'(redirect_target);
      else m_pc = (m_pc + 4) & M32;
      if (halt_req || m_hp) begin m_phase = P_HALT; m_hp = 0; end
      else m_phase = P_OFFER;
    end else m_hp = m_hp | halt_req;
  endtask

  task automatic cyc();
    @(posedge clk);
    model();
    #1;
    chk("pc", pc, m_pc);
    chk("epc", epc, m_epc);
    chk("pc_valid", pc_valid, m_phase == P_OFFER);
    chk("halted", halted, m_phase == P_HALT);
    chk("misaligned", misaligned, m_mis);
  endtask

  task automatic idle();
    fetch_ready = 0; advance = 0; redirect_valid = 0; redirect_target = 0;
    trap_req = 0; mret = 0; halt_req = 0; resume = 0;
  endtask

  task automatic to_exec();
    idle(); fetch_ready = 1;
    for (int i = 0; i < 8 && m_phase != P_EXEC; i++) cyc();
    chk("reach_exec_valid", pc_valid, 1'b0);
  endtask

  task automatic resolve(input bit t, m, r, a, h, input logic [31:0] tgt);
    to_exec();
    fetch_ready = 0; trap_req = t; mret = m; redirect_valid = r; advance = a;
    halt_req = h; redirect_target = tgt;
    cyc();
    idle();
  endtask

  initial begin
    idle(); rst_n = 0;
    cyc(); cyc();
    chk("rst_pc", pc, 32'h0); chk("rst_valid", pc_valid, 1'b0);
    rst_n = 1;
    cyc();
    chk("first_valid", pc_valid, 1'b1);
    fetch_ready = 1; advance = 1;
    for (int k = 0; k < 4; k++) begin
      chk("seq_pc", pc, 32'(4 * k)); chk("seq_valid", pc_valid, 1'b1);
      cyc();
      chk("seq_exec_valid", pc_valid, 1'b0);
      cyc();
    end
    resolve(0, 0, 1, 0, 0, 32'h40);
    resolve(0, 0, 1, 0, 0, 32'h200);
    chk("redir_pc", pc, 32'h200);
    resolve(0, 0, 1, 0, 0, 32'h40);
    resolve(0, 0, 1, 0, 0, 32'h202);
    chk("mis_pc", pc, 32'h100); chk("mis_epc", epc, 32'h40); chk("mis_pulse", misaligned, 1'b1);
    cyc();
    chk("mis_drop", misaligned, 1'b0);
    resolve(0, 0, 1, 0, 0, 32'h80);
    resolve(1, 0, 1, 0, 0, 32'h200);
    chk("trap_pc", pc, 32'h100); chk("trap_epc", epc, 32'h80); chk("trap_nomis", misaligned, 1'b0);
    resolve(0, 1, 0, 1, 0, 32'h0);
    chk("mret_pc", pc, 32'h80);
    advance = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_pc", pc, 32'h80); chk("stall_valid", pc_valid, 1'b1);
    end
    resolve(0, 0, 1, 0, 0, 32'h10);
    resolve(0, 0, 0, 1, 1, 32'h0);
    chk("halt_flag", halted, 1'b1); chk("halt_pc", pc, 32'h14); chk("halt_valid", pc_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("halt_hold", pc_valid, 1'b0);
    end
    resume = 1;
    cyc();
    idle();
    chk("resume_valid", pc_valid, 1'b1); chk("resume_pc", pc, 32'h14); chk("resume_flag", halted, 1'b0);
    resolve(0, 0, 1, 0, 0, 32'hFFFF_FFFC);
    resolve(0, 0, 0, 1, 0, 32'h0);
    chk("wrap_pc", pc, 32'h0);
    halt_req = 1;
    cyc();
    halt_req = 0;
    resolve(0, 0, 0, 1, 0, 32'h0);
    chk("latched_halt", halted, 1'b1); chk("latched_pc", pc, 32'h4);
    resume = 1;
    cyc();
    to_exec();
    rst_n = 0;
    cyc();
    chk("midrst_pc", pc, 32'h0); chk("midrst_epc", epc, 32'h0); chk("midrst_valid", pc_valid, 1'b0);
    rst_n = 1;
    cyc();
    chk("midrst_boot", pc_valid, 1'b1);
    for (int i = 0; i < 4000; i++) begin
      rst_n           = ($urandom_range(0, 199) != 0);
      fetch_ready     = ($urandom_range(0, 2) != 0);
      advance         = ($urandom_range(0, 1) != 0);
      redirect_valid  = ($urandom_range(0, 3) == 0);
      redirect_target = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
      trap_req        = ($urandom_range(0, 9) == 0);
      mret            = ($urandom_range(0, 9) == 0);
      halt_req        = ($urandom_range(0, 19) == 0);
      resume          = ($urandom_range(0, 3) == 0);
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
